// File: rtl/move_sequencer.sv
// move_sequencer: queues debounced move-key presses and issues one legal move at a time
// to the vertical-motion counter, tracking the player's level with a per-move watchdog.
module move_sequencer #(
    parameter int LEVELS      = 4,
    parameter int START_LEVEL = 0,
    parameter int QDEPTH      = 4,
    parameter int TIMEOUT     = 32,
    localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1,
    localparam int QW = $clog2(QDEPTH),
    localparam int WW = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [2:0]    keys,
    input  logic          update,
    input  logic          move_over,
    output logic [1:0]    move,
    output logic [LW-1:0] level,
    output logic          busy,
    output logic [QW:0]   q_count,
    output logic          reject,
    output logic          overflow,
    output logic          fault
);
    typedef enum logic [1:0] {IDLE, ACTIVE, SETTLE} state_t;

    state_t          state, state_n;
    logic [2:0]      s1, s2, s3, fall;
    logic [1:0]      mem [QDEPTH];
    logic [QW-1:0]   wp, rp;
    logic [1:0]      req, head, move_n;
    logic [LW-1:0]   level_n;
    logic [WW-1:0]   wd, wd_n;
    logic            full, pop, push, legal, rej_n, flt_n, ovf_n;

    always_comb begin
        fall    = s3 & ~s2;
        req     = fall[0] ? 2'b01 : fall[1] ? 2'b10 : fall[2] ? 2'b11 : 2'b00;
        full    = q_count == (QW+1)'(QDEPTH);
        pop     = state == IDLE && update && q_count != '0;
        push    = |fall && (!full || pop);
        ovf_n   = |fall && full && !pop;
        head    = mem[rp];
        legal   = !(head == 2'b01 && level == LW'(LEVELS - 1)) && !(head == 2'b11 && level == '0);
        state_n = state;
        move_n  = move;
        level_n = level;
        wd_n    = wd;
        rej_n   = 1'b0;
        flt_n   = 1'b0;
        case (state)
            IDLE: if (pop) begin
                if (legal) begin
                    move_n  = head;
                    wd_n    = '0;
                    state_n = ACTIVE;
                end else begin
                    rej_n = 1'b1;
                end
            end
            ACTIVE: if (move_over) begin
                level_n = move == 2'b01 ? level + 1'b1 : move == 2'b11 ? level - 1'b1 : level;
                move_n  = 2'b00;
                state_n = SETTLE;
            end else if (update) begin
                // the strobe that would bring the count to TIMEOUT aborts the move
                if (wd == WW'(TIMEOUT - 1)) begin
                    move_n  = 2'b00;
                    flt_n   = 1'b1;
                    state_n = SETTLE;
                end else begin
                    wd_n = wd + 1'b1;
                end
            end
            default: if (!move_over) state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            s1       <= 3'b111;
            s2       <= 3'b111;
            s3       <= 3'b111;
            wp       <= '0;
            rp       <= '0;
            q_count  <= '0;
            move     <= 2'b00;
            level    <= LW'(START_LEVEL);
            wd       <= '0;
            reject   <= 1'b0;
            overflow <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_n;
            s1       <= keys;
            s2       <= s1;
            s3       <= s2;
            wp       <= push ? wp + 1'b1 : wp;
            rp       <= pop ? rp + 1'b1 : rp;
            q_count  <= q_count + (QW+1)'(push) - (QW+1)'(pop);
            move     <= move_n;
            level    <= level_n;
            wd       <= wd_n;
            reject   <= rej_n;
            overflow <= ovf_n;
            fault    <= flt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= req;
    end

    assign busy = state != IDLE;
endmodule
